// File: rtl/limiter_scheduler.sv
// rtl/limiter_scheduler.sv - round-robin shared clamp stage with per-channel programmable limits
// Optional saturation counters: define LIMITER_SAT_COUNT_EN.
module limiter_scheduler #(
   parameter int BITS      = 11,
   parameter int CH        = 4,
   parameter int LIMIT_DEF = 1000
`ifdef LIMITER_SAT_COUNT_EN
   ,
   parameter int CNT_W     = 16
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CH-1:0]         req_valid,
   input  logic [CH*BITS-1:0]    req_data,
   output logic [CH-1:0]         req_ready,
   input  logic                  lim_we,
   input  logic [$clog2(CH)-1:0] lim_sel,
   input  logic [BITS-1:0]       lim_val,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BITS-1:0]       out_data,
   output logic [$clog2(CH)-1:0] out_ch,
   output logic                  out_sat,
`ifdef LIMITER_SAT_COUNT_EN
   input  logic                  cnt_clr,
   output logic [CH*CNT_W-1:0]   sat_cnt,
`endif
   output logic                  busy
);

   localparam int SW = $clog2(CH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CLAMP = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   logic [1:0]          state;
   logic [SW-1:0]       rr_ptr;
   logic [SW-1:0]       grant;
   logic [SW-1:0]       next_ptr;
   logic                grant_found;
   logic [BITS-1:0]     cur_x;
   logic [SW-1:0]       cur_ch;
   logic [BITS-1:0]     lim [CH];
   logic [BITS-1:0]     cur_lim;
   logic signed [BITS:0] x_ext;
   logic signed [BITS:0] lim_ext;
   logic signed [BITS:0] neg_lim;
   logic [BITS-1:0]     cl_data;
   logic                cl_sat;
   logic                handshake;

   assign busy      = (state != S_IDLE);
   assign handshake = (state == S_HOLD) && out_valid && out_ready;
   assign next_ptr  = (grant == SW'(CH - 1)) ? '0 : grant + 1'b1;

   // Round-robin search: first requesting channel at or after rr_ptr, wrapping modulo CH
   always_comb begin
      int idx;
      idx         = 0;
      grant       = '0;
      grant_found = 1'b0;
      for (int k = 0; k < CH; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= CH) idx = idx - CH;
         if (!grant_found && req_valid[SW'(idx)]) begin
            grant_found = 1'b1;
            grant       = SW'(idx);
         end
      end
   end

   // One-hot accept strobe, only while idle and out of reset
   always_comb begin
      req_ready = '0;
      if (rst && (state == S_IDLE) && grant_found) req_ready[grant] = 1'b1;
   end

   // Clamp of the captured sample; one extra bit keeps -2^(BITS-1) and -lim representable
   always_comb begin
      cur_lim = '0;
      for (int i = 0; i < CH; i++)
         if (cur_ch == SW'(i)) cur_lim = lim[i];
      x_ext   = {cur_x[BITS-1], cur_x};
      lim_ext = {1'b0, cur_lim};
      neg_lim = -lim_ext;
      cl_data = cur_x;
      cl_sat  = 1'b0;
      if (x_ext > lim_ext) begin
         cl_data = cur_lim;
         cl_sat  = 1'b1;
      end else if (x_ext < neg_lim) begin
         cl_data = neg_lim[BITS-1:0];
         cl_sat  = 1'b1;
      end
   end

   // Scheduler FSM: accept in IDLE, clamp once, hold the result until taken
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         rr_ptr    <= '0;
         cur_x     <= '0;
         cur_ch    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         out_sat   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_found) begin
                  cur_x  <= req_data[int'(grant)*BITS +: BITS];
                  cur_ch <= grant;
                  rr_ptr <= next_ptr;
                  state  <= S_CLAMP;
               end
            end
            S_CLAMP: begin
               out_data  <= cl_data;
               out_ch    <= cur_ch;
               out_sat   <= cl_sat;
               out_valid <= 1'b1;
               state     <= S_HOLD;
            end
            S_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Limit table; negative writes store 0, out-of-range indices match no entry
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < CH; i++) lim[i] <= BITS'(LIMIT_DEF);
      end else if (lim_we) begin
         for (int i = 0; i < CH; i++)
            if (int'(lim_sel) == i) lim[i] <= lim_val[BITS-1] ? '0 : lim_val;
      end
   end

`ifdef LIMITER_SAT_COUNT_EN
   logic [CNT_W-1:0] cnt [CH];

   // Per-channel saturation counters, sticky at all-ones, clear wins over increment
   always_ff @(posedge clk) begin
      if (!rst || cnt_clr) begin
         for (int i = 0; i < CH; i++) cnt[i] <= '0;
      end else if (handshake && out_sat) begin
         for (int i = 0; i < CH; i++)
            if ((out_ch == SW'(i)) && (cnt[i] != {CNT_W{1'b1}})) cnt[i] <= cnt[i] + 1'b1;
      end
   end

   // Flatten counters onto the output bus
   always_comb begin
      sat_cnt = '0;
      for (int i = 0; i < CH; i++) sat_cnt[i*CNT_W +: CNT_W] = cnt[i];
   end
`endif

endmodule

// File: tb/tb_limiter_scheduler.sv
// tb/tb_limiter_scheduler.sv - directed self-checking bench for limiter_scheduler
module tb_limiter_scheduler;

   localparam int BITS = 11;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [3:0]  req_valid;
   logic [43:0] req_data;
   logic [3:0]  req_ready;
   logic        lim_we;
   logic [1:0]  lim_sel;
   logic [10:0] lim_val;
   logic        out_valid;
   logic        out_ready;
   logic [10:0] out_data;
   logic [1:0]  out_ch;
   logic        out_sat;
   logic        busy;

   logic [4:0]  v5;
   logic [54:0] d5;
   logic [4:0]  r5;
   logic        we5;
   logic [2:0]  sel5;
   logic [10:0] val5;
   logic        ov5;
   logic        ordy5;
   logic [10:0] od5;
   logic [2:0]  oc5;
   logic        os5;
   logic        b5;

`ifdef LIMITER_SAT_COUNT_EN
   logic        cnt_clr;
   logic [63:0] sat_cnt;
   logic [79:0] sat_cnt5;
`endif

   limiter_scheduler #(.BITS(11), .CH(4), .LIMIT_DEF(1000)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .lim_we(lim_we), .lim_sel(lim_sel), .lim_val(lim_val), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch), .out_sat(out_sat),
`ifdef LIMITER_SAT_COUNT_EN
      .cnt_clr(cnt_clr), .sat_cnt(sat_cnt),
`endif
      .busy(busy)
   );

   limiter_scheduler #(.BITS(11), .CH(5), .LIMIT_DEF(1000)) u_dut5 (
      .clk(clk), .rst(rst), .req_valid(v5), .req_data(d5), .req_ready(r5),
      .lim_we(we5), .lim_sel(sel5), .lim_val(val5), .out_valid(ov5),
      .out_ready(ordy5), .out_data(od5), .out_ch(oc5), .out_sat(os5),
`ifdef LIMITER_SAT_COUNT_EN
      .cnt_clr(cnt_clr), .sat_cnt(sat_cnt5),
`endif
      .busy(b5)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wr_lim(input int sel, input int val);
      lim_we  = 1'b1;
      lim_sel = 2'(sel);
      lim_val = 11'(val);
      tick;
      lim_we  = 1'b0;
   endtask

   task automatic send(input int ch, input int val, input int exp_d, input logic exp_s, input string tag);
      req_data = '0;
      req_data[ch*BITS +: BITS] = 11'(val);
      req_valid = 4'b0001 << ch;
      #1 chk({tag, ".ready"}, req_ready, 32'sd1 << ch);
      tick;
      req_valid = '0;
      chk({tag, ".clamp_valid"}, out_valid, 0);
      chk({tag, ".clamp_busy"}, busy, 1);
      chk({tag, ".clamp_ready"}, req_ready, 0);
      tick;
      chk({tag, ".valid"}, out_valid, 1);
      chk({tag, ".data"}, $signed(out_data), exp_d);
      chk({tag, ".ch"}, out_ch, ch);
      chk({tag, ".sat"}, out_sat, exp_s);
      if (out_ready) begin
         tick;
         chk({tag, ".done_valid"}, out_valid, 0);
         chk({tag, ".done_busy"}, busy, 0);
      end
   endtask

   task automatic wr5(input int sel, input int val);
      we5  = 1'b1;
      sel5 = 3'(sel);
      val5 = 11'(val);
      tick;
      we5  = 1'b0;
   endtask

   task automatic send5(input int ch, input int val, input int exp_d, input logic exp_s, input string tag);
      d5 = '0;
      d5[ch*BITS +: BITS] = 11'(val);
      v5 = 5'b00001 << ch;
      #1 chk({tag, ".ready"}, r5, 32'sd1 << ch);
      tick;
      v5 = '0;
      tick;
      chk({tag, ".data"}, $signed(od5), exp_d);
      chk({tag, ".ch"}, oc5, ch);
      chk({tag, ".sat"}, os5, exp_s);
      tick;
   endtask

   initial begin
      rst = 1'b0; req_valid = 4'hF; req_data = '0; lim_we = 1'b0; lim_sel = '0; lim_val = '0;
      out_ready = 1'b1;
      v5 = '0; d5 = '0; we5 = 1'b0; sel5 = '0; val5 = '0; ordy5 = 1'b1;
`ifdef LIMITER_SAT_COUNT_EN
      cnt_clr = 1'b0;
`endif
      // reset state, req_ready gated while rst=0 even with requests pending
      tick;
      tick;
      chk("rst.ready", req_ready, 0);
      chk("rst.valid", out_valid, 0);
      chk("rst.busy", busy, 0);
      chk("rst.data", out_data, 0);
      chk("rst.ch", out_ch, 0);
      chk("rst.sat", out_sat, 0);
      req_valid = '0;
      rst = 1'b1;
      tick;

      // basic pass-through and latency
      send(0, 500, 500, 1'b0, "t1");

      // default limit boundaries on ch1
      send(1, 1023, 1000, 1'b1, "t2a");
      send(1, -1024, -1000, 1'b1, "t2b");
      send(1, 1000, 1000, 1'b0, "t2c");
      send(1, -1000, -1000, 1'b0, "t2d");

      // back-pressure in HOLD on ch3 (also returns rr_ptr to 0)
      out_ready = 1'b0;
      send(3, -1024, -1000, 1'b1, "t5");
      req_valid = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("t5.hold_valid", out_valid, 1);
         chk("t5.hold_data", $signed(out_data), -1000);
         chk("t5.hold_ch", out_ch, 3);
         chk("t5.hold_sat", out_sat, 1);
         chk("t5.hold_ready", req_ready, 0);
      end
      req_valid = '0;
      out_ready = 1'b1;
      tick;
      chk("t5.release_valid", out_valid, 0);
      chk("t5.release_busy", busy, 0);

      // round-robin fairness with all channels requesting
      req_data = {11'd30, 11'd20, 11'd10, 11'd0};
      req_valid = 4'hF;
      for (int g = 0; g < 8; g++) begin
         #1 chk("t3.grant", req_ready, 32'sd1 << (g % 4));
         tick;
         tick;
         chk("t3.out_ch", out_ch, g % 4);
         chk("t3.out_data", $signed(out_data), (g % 4) * 10);
         tick;
      end
      req_valid = '0;

      // programmable limits on ch2
      wr_lim(2, 200);
      send(2, 300, 200, 1'b1, "t4a");
      send(2, -300, -200, 1'b1, "t4b");
      wr_lim(2, -50);
      send(2, 7, 0, 1'b1, "t4c");
      send(2, -7, 0, 1'b1, "t4d");
      send(1, 1023, 1000, 1'b1, "t4e");

      // reset during HOLD, coincident with a handshake
      wr_lim(3, 50);
      out_ready = 1'b0;
      send(3, 100, 50, 1'b1, "t6a");
      rst = 1'b0;
      out_ready = 1'b1;
      tick;
      rst = 1'b1;
      chk("t6.valid", out_valid, 0);
      chk("t6.busy", busy, 0);
      chk("t6.data", out_data, 0);
      chk("t6.sat", out_sat, 0);
      req_data = '0;
      req_data[0 +: BITS]  = 11'd5;
      req_data[33 +: BITS] = 11'd1023;
      req_valid = 4'b1001;
      #1 chk("t6.rr_reset", req_ready, 4'b0001);
      tick;
      req_valid = 4'b1000;
      tick;
      chk("t6.ch0_ch", out_ch, 0);
      chk("t6.ch0_data", $signed(out_data), 5);
      tick;
      #1 chk("t6.ch3_grant", req_ready, 4'b1000);
      tick;
      req_valid = '0;
      tick;
      chk("t6.lim3_data", $signed(out_data), 1000);
      chk("t6.lim3_sat", out_sat, 1);
      tick;

      // out-of-range limit writes on a five-channel instance
      wr5(5, 10);
      wr5(7, 10);
      send5(1, 1023, 1000, 1'b1, "t4f");
      send5(4, 1023, 1000, 1'b1, "t4g");
      wr5(4, 10);
      send5(4, 1023, 10, 1'b1, "t4h");
      send5(0, -1024, -1000, 1'b1, "t4i");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
